hpb_wr_sched: RTL and testbench
===============================

Name: hpb_wr_sched

Overview:
Host-side write scheduler for the per-symbol parameter RAM control block.
- Accepts host configuration writes over a valid/ready interface and buffers them in a small FIFO.
- Issues writes one at a time through the RAM controller's hpb_wr_req / rcb_wr_done handshake, including the mandatory request de-assert gap.
- Raises a hold request to the feed-decoder path when a write has waited too long behind lookup reads.
- Sits between the host config register block and the RAM control block.

Parameters:
RCB_RAM_WIDTH, 64, width of one RAM entry and of write data; must be a multiple of 8.
FIFO_DEPTH, 4, write-queue entries; power of 2, minimum 2.
STARVE_LIMIT, 32, cycles in REQ without rcb_wr_done before starve_hold asserts; range 1..65535.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
host_wr_valid  in  1  host write offer
host_wr_ready  out  1  FIFO can accept (= !full)
host_wr_addr  in  14  symbol RAM address
host_wr_data  in  RCB_RAM_WIDTH  write data
host_wr_be  in  RCB_RAM_WIDTH/8  byte enables, bit i covers data[8i+7:8i]
host_flush  in  1  discard queued, not-yet-issued writes
hpb_wr_addr  out  14  address to RAM controller (FIFO head)
hpb_wr_data  out  RCB_RAM_WIDTH  data to RAM controller (FIFO head)
hpb_wr_en  out  RCB_RAM_WIDTH/8  byte enables to RAM controller (FIFO head)
hpb_wr_req  out  1  write request, level, held until done
rcb_wr_done  in  1  write accepted this cycle (RAM controller)
starve_hold  out  1  request feed decoder to suppress sef_read
wr_count  out  16  committed-write counter, wraps
sched_busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; FIFO empty, with read and write pointers at 0.
  - hpb_wr_req=0, starve_hold=0, wr_count=0, wait counter=0.
  - host_wr_ready=0 while reset_n is low; 1 after release.
  - hpb_wr_addr/data/en=0 when the FIFO is empty; otherwise they reflect the head entry, combinationally from the FIFO head.
- Push:
  - Occurs on a clk edge with host_wr_valid && host_wr_ready.
  - ready depends only on full, so a push when full is impossible.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- FSM:
  - IDLE: if FIFO non-empty, go to REQ.
  - REQ: hpb_wr_req=1 and the head outputs are stable. When rcb_wr_done=1 sampled at an edge: pop head, wr_count++, clear wait counter, go to GAP.
  - GAP: hpb_wr_req=0 for exactly one cycle, as the RAM controller ignores a request until it has been de-asserted. Then go to REQ if non-empty after the pop, else IDLE.
- Timing:
  - Push accepted at edge E0 gives hpb_wr_req high after E1.
  - Sustained throughput is one write per 2 cycles (REQ, GAP), assuming done returns in the first REQ cycle.
- rcb_wr_done outside REQ is ignored.
- Wait counter and starve_hold:
  - The 16-bit wait counter increments each REQ cycle without done and saturates at 0xFFFF.
  - starve_hold is registered: it goes to 1 on the edge where the counter reaches STARVE_LIMIT.
  - starve_hold clears on the edge where done is sampled, and stays 0 outside REQ.
- Flush (host_flush=1 at an edge):
  - In IDLE/GAP: FIFO emptied (write pointer set equal to read pointer). A concurrent push is dropped, but host_wr_ready still reflects the pre-flush state.
  - In REQ: the in-flight head is kept and all entries behind it are discarded. The in-flight write completes normally.
  - The FSM never aborts an asserted hpb_wr_req.
- wr_count wraps 0xFFFF to 0x0000.
- Reset mid-REQ: hpb_wr_req drops asynchronously and queued writes are lost; the host re-issues them.
- Pointers use log2(FIFO_DEPTH)+1 bits. full = MSBs differ and the rest are equal.

Test Plan:
- Single write: push addr=0x0123, data=0x1122334455667788, be=0xFF; done tied high in REQ -> hpb_wr_req high for exactly 1 cycle, 2 cycles after push; outputs match; wr_count=1; sched_busy=0 after GAP.
- Back-to-back: 4 pushes with FIFO_DEPTH=4 -> 5th offer sees ready=0 until the first pop; req pattern 1,0,1,0,1,0,1,0; addresses in order; wr_count=4.
- Starvation: done held low 40 cycles with STARVE_LIMIT=32 -> starve_hold rises on the 32nd REQ cycle, req held steady, starve_hold falls on the done edge.
- Flush during REQ: 3 queued, flush while head is in flight -> only the head commits; wr_count=1; FIFO empty; state IDLE.
- Spurious done in IDLE/GAP: no pop, no wr_count change.
- Async reset asserted mid-REQ -> hpb_wr_req=0 and starve_hold=0 immediately; after release, host_wr_ready=1, wr_count=0, FIFO empty.

Source files
------------

// File: rtl/hpb_wr_sched.sv
// hpb_wr_sched: host write queue feeding the RAM controller's req/done handshake with starvation hold
module hpb_wr_sched #(
  parameter int RCB_RAM_WIDTH = 64,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARVE_LIMIT  = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       host_wr_valid,
  output logic                       host_wr_ready,
  input  logic [13:0]                host_wr_addr,
  input  logic [RCB_RAM_WIDTH-1:0]   host_wr_data,
  input  logic [RCB_RAM_WIDTH/8-1:0] host_wr_be,
  input  logic                       host_flush,
  output logic [13:0]                hpb_wr_addr,
  output logic [RCB_RAM_WIDTH-1:0]   hpb_wr_data,
  output logic [RCB_RAM_WIDTH/8-1:0] hpb_wr_en,
  output logic                       hpb_wr_req,
  input  logic                       rcb_wr_done,
  output logic                       starve_hold,
  output logic [15:0]                wr_count,
  output logic                       sched_busy
);
  localparam int BW = RCB_RAM_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 14 + RCB_RAM_WIDTH + BW;
  localparam logic [15:0] LIM = 16'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t        state, state_nx;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [15:0]   wait_cnt, wait_nx;
  logic          empty, full, push, pop;

  assign empty         = wptr == rptr;
  assign full          = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign host_wr_ready = reset_n && !full;
  assign push          = host_wr_valid && host_wr_ready && !host_flush;
  assign pop           = (state == REQ) && rcb_wr_done;
  assign sched_busy    = !empty || (state != IDLE);
  assign wait_nx       = &wait_cnt ? wait_cnt : wait_cnt + 16'd1;
  assign {hpb_wr_addr, hpb_wr_data, hpb_wr_en} = empty ? '0 : mem[rptr[AW-1:0]];

  // queue storage; head is read combinationally so it is stable throughout REQ
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {host_wr_addr, host_wr_data, host_wr_be};
  end

  // pointers; a flush in REQ keeps the in-flight head, otherwise drops everything
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      rptr <= pop ? rptr + PW'(1) : rptr;
      wptr <= !host_flush ? (push ? wptr + PW'(1) : wptr) : (state == REQ ? rptr + PW'(1) : rptr);
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end

  // next state and request output; GAP forces the mandatory one-cycle request drop
  always_comb begin
    state_nx   = state;
    hpb_wr_req = 1'b0;
    unique case (state)
      IDLE: state_nx = (!empty && !host_flush) ? REQ : IDLE;
      REQ: begin
        hpb_wr_req = 1'b1;
        state_nx   = rcb_wr_done ? GAP : REQ;
      end
      GAP: state_nx = (!empty && !host_flush) ? REQ : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // wait counter, registered starvation hold and committed-write counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      starve_hold <= 1'b0;
      wr_count    <= '0;
    end else begin
      wait_cnt    <= (state == REQ && !rcb_wr_done) ? wait_nx : '0;
      starve_hold <= (state == REQ) && !rcb_wr_done && (wait_nx >= LIM);
      wr_count    <= wr_count + {15'd0, pop};
    end
  end
endmodule

// File: tb/tb_hpb_wr_sched.sv
// tb_hpb_wr_sched: directed self-checking bench for the host write scheduler
module tb_hpb_wr_sched;
  logic        clk = 0, reset_n = 0, host_wr_valid = 0, host_flush = 0, rcb_wr_done = 0;
  logic        host_wr_ready, hpb_wr_req, starve_hold, sched_busy;
  logic [13:0] host_wr_addr = '0, hpb_wr_addr;
  logic [63:0] host_wr_data = '0, hpb_wr_data;
  logic [7:0]  host_wr_be = '0, hpb_wr_en;
  logic [15:0] wr_count;
  int total = 0, bad = 0;

  hpb_wr_sched #(.RCB_RAM_WIDTH(64), .FIFO_DEPTH(4), .STARVE_LIMIT(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .host_wr_be(host_wr_be),
    .host_flush(host_flush),
    .hpb_wr_addr(hpb_wr_addr), .hpb_wr_data(hpb_wr_data), .hpb_wr_en(hpb_wr_en),
    .hpb_wr_req(hpb_wr_req), .rcb_wr_done(rcb_wr_done),
    .starve_hold(starve_hold), .wr_count(wr_count), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [13:0] a, input logic [63:0] d, input logic [7:0] be);
    host_wr_valid = 1;
    host_wr_addr  = a;
    host_wr_data  = d;
    host_wr_be    = be;
  endtask

  task automatic test_reset;
    reset_n = 0;
    #3;
    total++; if (host_wr_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", host_wr_ready); end
    total++; if (hpb_wr_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", hpb_wr_req); end
    total++; if (starve_hold !== 1'b0) begin bad++; $display("FAIL rst_starve: got %b want 0", starve_hold); end
    total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL rst_count: got %h want 0", wr_count); end
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", sched_busy); end
    total++; if ({hpb_wr_addr, hpb_wr_data, hpb_wr_en} !== '0) begin bad++; $display("FAIL rst_head: got %h/%h/%h want 0", hpb_wr_addr, hpb_wr_data, hpb_wr_en); end
    tick;
    reset_n = 1;
    #1;
    total++; if (host_wr_ready !== 1'b1) begin bad++; $display("FAIL rel_ready: got %b want 1", host_wr_ready); end
    tick;
  endtask

  task automatic test_single;
    rcb_wr_done = 1;
    offer(14'h0123, 64'h1122334455667788, 8'hFF);
    tick;
    host_wr_valid = 0;
    total++; if (hpb_wr_req !== 1'b0) begin bad++; $display("FAIL single_req_e0: got %b want 0", hpb_wr_req); end
    total++; if (sched_busy !== 1'b1) begin bad++; $display("FAIL single_busy_e0: got %b want 1", sched_busy); end
    tick;
    total++; if (hpb_wr_req !== 1'b1) begin bad++; $display("FAIL single_req_e1: got %b want 1", hpb_wr_req); end
    total++; if (hpb_wr_addr !== 14'h0123) begin bad++; $display("FAIL single_addr: got %h want 0123", hpb_wr_addr); end
    total++; if (hpb_wr_data !== 64'h1122334455667788) begin bad++; $display("FAIL single_data: got %h want 1122334455667788", hpb_wr_data); end
    total++; if (hpb_wr_en !== 8'hFF) begin bad++; $display("FAIL single_en: got %h want ff", hpb_wr_en); end
    tick;
    total++; if (hpb_wr_req !== 1'b0) begin bad++; $display("FAIL single_req_gap: got %b want 0", hpb_wr_req); end
    total++; if (wr_count !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", wr_count); end
    tick;
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle: got %b want 0", sched_busy); end
    total++; if (hpb_wr_req !== 1'b0) begin bad++; $display("FAIL single_req_idle: got %b want 0", hpb_wr_req); end
    rcb_wr_done = 0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      offer(14'h10 + 14'(i), 64'hA5A5_0000_0000_0000 | 64'(i), 8'h01 << i);
      tick;
    end
    offer(14'h14, 64'hDEAD, 8'hFF);
    total++; if (host_wr_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready: got %b want 0", host_wr_ready); end
    tick;
    total++; if (host_wr_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready2: got %b want 0", host_wr_ready); end
    host_wr_valid = 0;
    rcb_wr_done = 1;
    for (int i = 0; i < 8; i++) begin
      total++; if (hpb_wr_req !== (i % 2 == 0)) begin bad++; $display("FAIL b2b_req[%0d]: got %b want %b", i, hpb_wr_req, i % 2 == 0); end
      if (i % 2 == 0) begin
        total++; if (hpb_wr_addr !== 14'h10 + 14'(i / 2)) begin bad++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, hpb_wr_addr, 14'h10 + 14'(i / 2)); end
        total++; if (hpb_wr_data !== (64'hA5A5_0000_0000_0000 | 64'(i / 2))) begin bad++; $display("FAIL b2b_data[%0d]: got %h", i, hpb_wr_data); end
        total++; if (hpb_wr_en !== 8'h01 << (i / 2)) begin bad++; $display("FAIL b2b_en[%0d]: got %h want %h", i, hpb_wr_en, 8'h01 << (i / 2)); end
      end
      if (i == 1) begin
        total++; if (host_wr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_pop: got %b want 1", host_wr_ready); end
      end
      tick;
    end
    total++; if (wr_count !== 16'd5) begin bad++; $display("FAIL b2b_count: got %0d want 5", wr_count); end
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy: got %b want 0", sched_busy); end
    rcb_wr_done = 0;
  endtask

  task automatic test_starvation;
    offer(14'h200, 64'h55, 8'h0F);
    tick;
    host_wr_valid = 0;
    tick;
    for (int k = 1; k <= 40; k++) begin
      tick;
      total++; if (starve_hold !== (k >= 32)) begin bad++; $display("FAIL starve[%0d]: got %b want %b", k, starve_hold, k >= 32); end
      total++; if (hpb_wr_req !== 1'b1 || hpb_wr_addr !== 14'h200) begin bad++; $display("FAIL starve_req[%0d]: got %b/%h want 1/0200", k, hpb_wr_req, hpb_wr_addr); end
    end
    rcb_wr_done = 1;
    tick;
    rcb_wr_done = 0;
    total++; if (starve_hold !== 1'b0) begin bad++; $display("FAIL starve_clear: got %b want 0", starve_hold); end
    total++; if (wr_count !== 16'd6) begin bad++; $display("FAIL starve_count: got %0d want 6", wr_count); end
    tick;
  endtask

  task automatic test_flush_req;
    for (int i = 0; i < 3; i++) begin
      offer(14'h300 + 14'(i), 64'(i), 8'hFF);
      tick;
    end
    host_wr_valid = 0;
    host_flush = 1;
    tick;
    host_flush = 0;
    total++; if (hpb_wr_req !== 1'b1 || hpb_wr_addr !== 14'h300) begin bad++; $display("FAIL flush_head: got %b/%h want 1/0300", hpb_wr_req, hpb_wr_addr); end
    rcb_wr_done = 1;
    tick;
    rcb_wr_done = 0;
    total++; if (wr_count !== 16'd7) begin bad++; $display("FAIL flush_count: got %0d want 7", wr_count); end
    tick;
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", sched_busy); end
    tick;
    total++; if (hpb_wr_req !== 1'b0 || wr_count !== 16'd7) begin bad++; $display("FAIL flush_idle: got %b/%0d want 0/7", hpb_wr_req, wr_count); end
    offer(14'h3FF, 64'h1, 8'h1);
    host_flush = 1;
    total++; if (host_wr_ready !== 1'b1) begin bad++; $display("FAIL flush_ready: got %b want 1", host_wr_ready); end
    tick;
    host_wr_valid = 0;
    host_flush = 0;
    total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL flush_push_drop: got %b want 0", sched_busy); end
  endtask

  task automatic test_spurious_done;
    rcb_wr_done = 1;
    repeat (3) tick;
    total++; if (wr_count !== 16'd7 || sched_busy !== 1'b0) begin bad++; $display("FAIL spur_idle: got %0d/%b want 7/0", wr_count, sched_busy); end
    rcb_wr_done = 0;
    offer(14'h0042, 64'h42, 8'h42);
    tick;
    host_wr_valid = 0;
    tick;
    rcb_wr_done = 1;
    tick;
    total++; if (wr_count !== 16'd8) begin bad++; $display("FAIL spur_commit: got %0d want 8", wr_count); end
    tick;
    total++; if (wr_count !== 16'd8) begin bad++; $display("FAIL spur_gap: got %0d want 8", wr_count); end
    tick;
    total++; if (wr_count !== 16'd8 || sched_busy !== 1'b0) begin bad++; $display("FAIL spur_after: got %0d/%b want 8/0", wr_count, sched_busy); end
    rcb_wr_done = 0;
  endtask

  task automatic test_async_reset;
    offer(14'h400, 64'h4, 8'hFF);
    tick;
    offer(14'h401, 64'h5, 8'hFF);
    tick;
    host_wr_valid = 0;
    repeat (33) tick;
    total++; if (starve_hold !== 1'b1 || hpb_wr_req !== 1'b1) begin bad++; $display("FAIL ar_pre: got %b/%b want 1/1", starve_hold, hpb_wr_req); end
    #2;
    reset_n = 0;
    #1;
    total++; if (hpb_wr_req !== 1'b0) begin bad++; $display("FAIL ar_req: got %b want 0", hpb_wr_req); end
    total++; if (starve_hold !== 1'b0) begin bad++; $display("FAIL ar_starve: got %b want 0", starve_hold); end
    total++; if (host_wr_ready !== 1'b0) begin bad++; $display("FAIL ar_ready: got %b want 0", host_wr_ready); end
    tick;
    reset_n = 1;
    #1;
    total++; if (host_wr_ready !== 1'b1) begin bad++; $display("FAIL ar_rel_ready: got %b want 1", host_wr_ready); end
    total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL ar_count: got %0d want 0", wr_count); end
    total++; if (sched_busy !== 1'b0 || hpb_wr_addr !== 14'h0) begin bad++; $display("FAIL ar_empty: got %b/%h want 0/0000", sched_busy, hpb_wr_addr); end
    tick;
    total++; if (hpb_wr_req !== 1'b0) begin bad++; $display("FAIL ar_req_after: got %b want 0", hpb_wr_req); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_starvation;
    test_flush_req;
    test_spurious_done;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
